// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter and the LSU address decode.
//   uart_tx_state_e           transmitter FSM states
//   UART_FRAME_BITS           serial bits per frame, including start and stop
//   UART_DEFAULT_CLKS_PER_BIT 100 MHz core clock / 115200 baud
//   UART_DATA_ADDR            store address that launches a frame
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit, 8E1).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 11;
`else
  localparam int unsigned UART_FRAME_BITS = 10;
`endif

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam logic [31:0] UART_DATA_ADDR            = 32'h1000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter for the UART transmitter.
//   clk  in  core clock
//   rst  in  synchronous reset, active-high
//   clr  in  hold the counter at zero
//   tick out high in the last cycle of each bit period
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] r_cnt;

  assign tick = (r_cnt == CntW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN defined).
//   clk      in  core clock
//   rst      in  synchronous reset, active-high
//   tx_start in  one-cycle store strobe to the UART data address
//   tx_data  in  byte to send, sampled only when tx_start is accepted
//   t_byte_i out transmitter busy, drives the hazard unit stall
//   tx_done  out one-cycle pulse as a frame completes
//   tx_out   out serial line, idles high
// Optional feature macro: UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 t_byte_i,
  output logic                 tx_done,
  output logic                 tx_out
);

  uart_tx_state_e       r_state, w_state_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic [2:0]           r_idx, w_idx_d;
  logic                 r_busy, r_done, r_line;
  logic                 w_done_d, w_line_d;
  logic                 w_tick, w_clr;
`ifdef UART_TX_PARITY_EN
  logic                 r_par, w_par_d;
`endif

  // Held clear while idle so the first bit period starts at zero on acceptance.
  assign w_clr = (r_state == StIdle);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_idx_d   = r_idx;
    w_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_d   = r_par;
`endif
    unique case (r_state)
      StIdle: begin
        if (tx_start) begin
          w_shift_d = tx_data;
          w_idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          w_par_d   = ^tx_data;
`endif
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_tick) w_state_d = StData;
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = r_shift >> 1;
          w_idx_d   = r_idx + 3'd1;
          if (r_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_tick) w_state_d = StStop;
      end
`endif
      StStop: begin
        if (w_tick) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level is decoded from the next state so tx_out comes straight from a flop.
  always_comb begin
    w_line_d = 1'b1;
    unique case (w_state_d)
      StIdle:   w_line_d = 1'b1;
      StStart:  w_line_d = 1'b0;
      StData:   w_line_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: w_line_d = w_par_d;
`endif
      StStop:   w_line_d = 1'b1;
      default:  w_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_line  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_idx   <= w_idx_d;
      r_busy  <= (w_state_d != StIdle);
      r_done  <= w_done_d;
      r_line  <= w_line_d;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_d;
`endif
    end
  end

  assign t_byte_i = r_busy;
  assign tx_done  = r_done;
  assign tx_out   = r_line;

endmodule
